// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Memoria port arbiter.
// Optional round-robin arbitration is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   localparam int PORT_FETCH = 0;
   localparam int PORT_DATA  = 1;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   // Word accesses must have both byte-offset bits clear.
   function automatic logic is_misaligned(input logic [31:0] a);
      return (a[1:0] & ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_RR_EN defined: round-robin on contention; otherwise data beats fetch.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] pick
);

`ifdef MEM_ARB_RR_EN
   // On contention, favour whichever port was not granted last time.
   always_comb begin
      pick = req;
      if (&req) begin
         pick = 2'b00;
         if (last_gnt) pick[PORT_FETCH] = 1'b1;
         else          pick[PORT_DATA]  = 1'b1;
      end
   end
`else
   logic w_unused_last;
   assign w_unused_last = last_gnt;

   always_comb begin
      pick = 2'b00;
      if (req[PORT_DATA])       pick[PORT_DATA]  = 1'b1;
      else if (req[PORT_FETCH]) pick[PORT_FETCH] = 1'b1;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch/data accesses onto the single-port Memoria instance.
// Build option MEM_ARB_RR_EN enables round-robin arbitration (fixed priority otherwise).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 2
)(
   input  logic        clock,
   input  logic        reset_l,
   input  logic [1:0]  req,
   input  logic [1:0]  we,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  gnt,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic [31:0] rdata,
   output logic        busy
);

   arb_state_t  r_state;
   arb_state_t  w_state_next;
   logic [3:0]  r_wcnt;
   logic [1:0]  r_gnt;
   logic        r_err;
   logic        r_mem_wr;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;

   logic [1:0]  w_pick;
   logic        w_last_gnt;
   logic        w_sel_data;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_we;
   logic        w_misalign;
   logic        w_grant;

   mem_arb_pick u_pick (
      .req      (req),
      .last_gnt (w_last_gnt),
      .pick     (w_pick)
   );

   assign w_sel_data = w_pick[PORT_DATA];
   assign w_addr     = w_sel_data ? addr1  : addr0;
   assign w_wdata    = w_sel_data ? wdata1 : wdata0;
   assign w_we       = w_sel_data ? we[PORT_DATA] : we[PORT_FETCH];
   assign w_misalign = is_misaligned(w_addr);
   assign w_grant    = (r_state == ARB_IDLE) && (|req);

`ifdef MEM_ARB_RR_EN
   logic r_last_gnt;

   // Misaligned grants count too, so a faulting port cannot starve the other.
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l)     r_last_gnt <= 1'b0;
      else if (w_grant) r_last_gnt <= w_sel_data;
   end

   assign w_last_gnt = r_last_gnt;
`else
   assign w_last_gnt = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) r_state <= ARB_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (|req) w_state_next = w_misalign ? ARB_DONE : ARB_ACCESS;
         end
         ARB_ACCESS: begin
            if (r_wcnt == 4'd0) w_state_next = ARB_DONE;
         end
         ARB_DONE: w_state_next = ARB_IDLE;
         default:  w_state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         r_wcnt      <= 4'd0;
         r_gnt       <= 2'b00;
         r_err       <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_rdata     <= 32'd0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (|req) begin
                  r_gnt <= w_pick;
                  r_err <= w_misalign;
                  // A misaligned access never reaches the memory pins.
                  if (!w_misalign) begin
                     r_mem_addr  <= w_addr;
                     r_mem_wdata <= w_wdata;
                     r_mem_wr    <= w_we;
                     r_wcnt      <= 4'(WAIT_STATES);
                  end
               end
            end
            ARB_ACCESS: begin
               r_mem_wr <= 1'b0;
               if (r_wcnt != 4'd0) r_wcnt  <= r_wcnt - 4'd1;
               else                r_rdata <= mem_rdata;
            end
            ARB_DONE: begin
               r_gnt <= 2'b00;
               r_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_wr    = r_mem_wr;
   assign mem_wdata = r_mem_wdata;
   assign gnt       = r_gnt;
   assign rdata     = r_rdata;
   assign busy      = (r_state != ARB_IDLE);
   assign done      = (r_state == ARB_DONE) ? r_gnt : 2'b00;
   assign err       = ((r_state == ARB_DONE) && r_err) ? r_gnt : 2'b00;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a WS-deep pipelined memory model.
// Contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

   localparam int WS = 2;

   logic        clock = 1'b0;
   logic        reset_l;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [1:0]  gnt, done, err;
   logic [31:0] rdata;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Memory model: reads appear WS cycles after the address cycle.
   logic [31:0] mem [0:255];
   logic [31:0] rd_pipe [0:WS-1];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (pre_we)      mem[pre_idx] <= pre_data;
      else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
      rd_pipe[0] <= mem[mem_addr[9:2]];
      for (int k = 1; k < WS; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[WS-1];

   mem_port_arbiter #(.WAIT_STATES(WS)) dut (
      .clock     (clock),
      .reset_l   (reset_l),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .busy      (busy)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts in an IDLE cycle, runs until done (bounded), returns in the following IDLE cycle.
   task automatic do_txn(input logic [1:0] r, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1, input bit hold,
                         output int lat, output logic [1:0] dn, output logic [1:0] er,
                         output logic [31:0] rd, output int wrc);
      req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      lat = 0; wrc = 0;
      while (lat < 20) begin
         tick;
         lat++;
         if (mem_wr) wrc++;
         if (done != 2'b00) break;
      end
      dn = done; er = err; rd = rdata;
      $display("txn req=%b we=%b a0=%h a1=%h lat=%0d done=%b err=%b rdata=%h wr_cycles=%0d",
               r, w, a0, a1, lat, dn, er, rd, wrc);
      if (!hold) req = 2'b00;
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, wrc;
      logic [1:0]  dn, er;
      logic [31:0] rd;
      logic [31:0] prev_addr, prev_wdata, prev_rdata;

      reset_l = 1'b0;
      req = 2'b00; we = 2'b00;
      addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
      pre_we = 1'b0; pre_idx = 8'd0; pre_data = 32'd0;

      // Preload memory while in reset.
      for (int i = 0; i < 256; i++) begin
         pre_idx  = 8'(i);
         pre_data = (i == 2) ? 32'h2008_0005 : {24'hA5A5A5, 8'(i)};
         pre_we   = 1'b1;
         tick;
      end
      pre_we = 1'b0;

      chk("rst_mem_addr",  mem_addr,  32'd0);
      chk("rst_mem_wr",    {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_gnt",       {30'd0, gnt},  32'd0);
      chk("rst_done",      {30'd0, done}, 32'd0);
      chk("rst_err",       {30'd0, err},  32'd0);
      chk("rst_rdata",     rdata,     32'd0);
      chk("rst_busy",      {31'd0, busy}, 32'd0);

      reset_l = 1'b1;
      tick;

      // Fetch read, cycle by cycle.
      req = 2'b01; we = 2'b00; addr0 = 32'h0000_0008;
      chk("rd_t0_busy", {31'd0, busy}, 32'd0);
      tick;
      chk("rd_t1_addr", mem_addr, 32'h8);
      chk("rd_t1_gnt",  {30'd0, gnt}, 32'd1);
      chk("rd_t1_busy", {31'd0, busy}, 32'd1);
      chk("rd_t1_wr",   {31'd0, mem_wr}, 32'd0);
      chk("rd_t1_done", {30'd0, done}, 32'd0);
      tick;
      chk("rd_t2_addr", mem_addr, 32'h8);
      chk("rd_t2_wr",   {31'd0, mem_wr}, 32'd0);
      tick;
      chk("rd_t3_addr", mem_addr, 32'h8);
      chk("rd_t3_done", {30'd0, done}, 32'd0);
      tick;
      chk("rd_t4_done",  {30'd0, done}, 32'd1);
      chk("rd_t4_err",   {30'd0, err},  32'd0);
      chk("rd_t4_rdata", rdata, 32'h2008_0005);
      chk("rd_t4_wr",    {31'd0, mem_wr}, 32'd0);
      $display("txn fetch read addr=00000008 done=%b rdata=%h", done, rdata);
      req = 2'b00;
      tick;
      chk("rd_t5_busy",  {31'd0, busy}, 32'd0);
      chk("rd_t5_gnt",   {30'd0, gnt},  32'd0);
      chk("rd_t5_done",  {30'd0, done}, 32'd0);
      chk("rd_t5_rdata", rdata, 32'h2008_0005);

      // Data store.
      do_txn(2'b10, 2'b10, 32'h0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, lat, dn, er, rd, wrc);
      chk("st_lat",    32'(lat), 32'd4);
      chk("st_done",   {30'd0, dn}, 32'd2);
      chk("st_err",    {30'd0, er}, 32'd0);
      chk("st_wr_cnt", 32'(wrc), 32'd1);
      chk("st_wdata",  mem_wdata, 32'hDEAD_BEEF);
      chk("st_busy",   {31'd0, busy}, 32'd0);

      do_txn(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0, lat, dn, er, rd, wrc);
      chk("st_rb_lat",   32'(lat), 32'd4);
      chk("st_rb_done",  {30'd0, dn}, 32'd1);
      chk("st_rb_rdata", rd, 32'hDEAD_BEEF);
      chk("st_rb_wr",    32'(wrc), 32'd0);

      // Contention: req=11 held across two transactions.
      do_txn(2'b11, 2'b00, 32'h8, 32'h40, 32'h0, 32'h0, 1'b1, lat, dn, er, rd, wrc);
      chk("ct1_lat",   32'(lat), 32'd4);
      chk("ct1_done",  {30'd0, dn}, 32'd2);
      chk("ct1_rdata", rd, 32'hDEAD_BEEF);
      do_txn(2'b11, 2'b00, 32'h8, 32'h40, 32'h0, 32'h0, 1'b0, lat, dn, er, rd, wrc);
      chk("ct2_lat", 32'(lat), 32'd4);
`ifdef MEM_ARB_RR_EN
      chk("ct2_done",  {30'd0, dn}, 32'd1);
      chk("ct2_rdata", rd, 32'h2008_0005);
`else
      chk("ct2_done",  {30'd0, dn}, 32'd2);
      chk("ct2_rdata", rd, 32'hDEAD_BEEF);
`endif

      // Misaligned store on the data port.
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_rdata = rdata;
      do_txn(2'b10, 2'b10, 32'h0, 32'h42, 32'h0, 32'h1234_5678, 1'b0, lat, dn, er, rd, wrc);
      chk("mis_lat",    32'(lat), 32'd1);
      chk("mis_done",   {30'd0, dn}, 32'd2);
      chk("mis_err",    {30'd0, er}, 32'd2);
      chk("mis_wr_cnt", 32'(wrc), 32'd0);
      chk("mis_addr",   mem_addr,  prev_addr);
      chk("mis_wdata",  mem_wdata, prev_wdata);
      chk("mis_rdata",  rd, prev_rdata);
      chk("mis_err_clr", {30'd0, err}, 32'd0);

      do_txn(2'b01, 2'b00, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, lat, dn, er, rd, wrc);
      chk("mis0_lat",  32'(lat), 32'd1);
      chk("mis0_done", {30'd0, dn}, 32'd1);
      chk("mis0_err",  {30'd0, er}, 32'd1);

      do_txn(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0, lat, dn, er, rd, wrc);
      chk("mis_mem_intact", rd, 32'hDEAD_BEEF);

      // Reset during the second ACCESS cycle of a store.
      req = 2'b10; we = 2'b10; addr1 = 32'h80; wdata1 = 32'hCAFE_F00D;
      tick;
      chk("rs_t1_wr", {31'd0, mem_wr}, 32'd1);
      tick;
      chk("rs_t2_busy", {31'd0, busy}, 32'd1);
      #1 reset_l = 1'b0;
      #1;
      chk("rs_wr",   {31'd0, mem_wr}, 32'd0);
      chk("rs_gnt",  {30'd0, gnt},  32'd0);
      chk("rs_busy", {31'd0, busy}, 32'd0);
      chk("rs_addr", mem_addr, 32'd0);
      chk("rs_done", {30'd0, done}, 32'd0);
      $display("txn store aborted by reset addr=00000080");
      req = 2'b00;
      tick;
      tick;
      reset_l = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick;
         chk("rs_no_done", {30'd0, done}, 32'd0);
      end

      do_txn(2'b10, 2'b10, 32'h0, 32'h80, 32'h0, 32'hCAFE_F00D, 1'b0, lat, dn, er, rd, wrc);
      chk("rs_re_lat",  32'(lat), 32'd4);
      chk("rs_re_done", {30'd0, dn}, 32'd2);
      chk("rs_re_wr",   32'(wrc), 32'd1);
      do_txn(2'b01, 2'b00, 32'h80, 32'h0, 32'h0, 32'h0, 1'b0, lat, dn, er, rd, wrc);
      chk("rs_rb_rdata", rd, 32'hCAFE_F00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
